// File: rtl/bus_arbiter.sv
// Two-port (instruction / data) arbiter onto one shared memory port.
// Only one memory transaction is outstanding; ties go round-robin or always to I.
module bus_arbiter #(
   parameter bit RR_EN = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        i_valid,
   output logic        i_ready,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_wstrb,
   output logic [31:0] i_rdata,
   input  logic        d_valid,
   output logic        d_ready,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic [31:0] d_rdata,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   input  logic [31:0] m_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;

   state_e      state_q, state_d;
   logic        grant_q, grant_d;
   logic        last_grant_q, last_grant_d;
   logic        m_valid_q, m_valid_d;
   logic [31:0] m_addr_q, m_addr_d;
   logic [31:0] m_wdata_q, m_wdata_d;
   logic [3:0]  m_wstrb_q, m_wstrb_d;
   logic        i_ready_q, i_ready_d;
   logic        d_ready_q, d_ready_d;
   logic [31:0] i_rdata_q, i_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic        pick;

   // State and output registers; last_grant resets to D so the first tie goes to I.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         grant_q      <= GNT_I;
         last_grant_q <= GNT_D;
         m_valid_q    <= 1'b0;
         m_addr_q     <= 32'h0000_0000;
         m_wdata_q    <= 32'h0000_0000;
         m_wstrb_q    <= 4'h0;
         i_ready_q    <= 1'b0;
         d_ready_q    <= 1'b0;
         i_rdata_q    <= 32'h0000_0000;
         d_rdata_q    <= 32'h0000_0000;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         m_valid_q    <= m_valid_d;
         m_addr_q     <= m_addr_d;
         m_wdata_q    <= m_wdata_d;
         m_wstrb_q    <= m_wstrb_d;
         i_ready_q    <= i_ready_d;
         d_ready_q    <= d_ready_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   // Next-state logic: arbitrate in IDLE, wait for memory in BUSY, one ready cycle in RESP.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      m_valid_d    = m_valid_q;
      m_addr_d     = m_addr_q;
      m_wdata_d    = m_wdata_q;
      m_wstrb_d    = m_wstrb_q;
      i_ready_d    = 1'b0;
      d_ready_d    = 1'b0;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      pick         = GNT_I;

      case (state_q)
         ST_IDLE: begin
            if (i_valid && d_valid) begin
               if (RR_EN == 1'b1) begin
                  pick = ~last_grant_q;
               end else begin
                  pick = GNT_I;
               end
            end else if (d_valid) begin
               pick = GNT_D;
            end else begin
               pick = GNT_I;
            end

            if (i_valid || d_valid) begin
               state_d      = ST_BUSY;
               m_valid_d    = 1'b1;
               grant_d      = pick;
               last_grant_d = pick;
               if (pick == GNT_D) begin
                  m_addr_d  = d_addr;
                  m_wdata_d = d_wdata;
                  m_wstrb_d = d_wstrb;
               end else begin
                  m_addr_d  = i_addr;
                  m_wdata_d = i_wdata;
                  m_wstrb_d = i_wstrb;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            // Completion is taken even if the granted requester has dropped valid.
            if (m_ready) begin
               state_d   = ST_RESP;
               m_valid_d = 1'b0;
               if (grant_q == GNT_D) begin
                  d_ready_d = 1'b1;
                  d_rdata_d = m_rdata;
               end else begin
                  i_ready_d = 1'b1;
                  i_rdata_d = m_rdata;
               end
            end else begin
               state_d = ST_BUSY;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign i_ready = i_ready_q;
   assign d_ready = d_ready_q;
   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;
   assign m_valid = m_valid_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;
   assign m_wstrb = m_wstrb_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a round-robin instance and a fixed-priority
// instance share all inputs; expected values are hand-computed constants.
module tb_bus_arbiter;

   logic        clk;
   logic        resetn;
   logic        i_valid, d_valid, m_ready;
   logic [31:0] i_addr, i_wdata, d_addr, d_wdata, m_rdata;
   logic [3:0]  i_wstrb, d_wstrb;

   logic        i_ready, d_ready, m_valid;
   logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
   logic [3:0]  m_wstrb;

   logic        i_ready_f, d_ready_f, m_valid_f;
   logic [31:0] i_rdata_f, d_rdata_f, m_addr_f, m_wdata_f;
   logic [3:0]  m_wstrb_f;

   int n_chk;
   int n_fail;

   bus_arbiter #(.RR_EN(1'b1)) u_rr (
      .clk(clk), .resetn(resetn),
      .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_wstrb(i_wstrb), .i_rdata(i_rdata),
      .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_rdata(d_rdata),
      .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_wstrb(m_wstrb), .m_rdata(m_rdata)
   );

   bus_arbiter #(.RR_EN(1'b0)) u_fix (
      .clk(clk), .resetn(resetn),
      .i_valid(i_valid), .i_ready(i_ready_f), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_wstrb(i_wstrb), .i_rdata(i_rdata_f),
      .d_valid(d_valid), .d_ready(d_ready_f), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_rdata(d_rdata_f),
      .m_valid(m_valid_f), .m_ready(m_ready), .m_addr(m_addr_f), .m_wdata(m_wdata_f),
      .m_wstrb(m_wstrb_f), .m_rdata(m_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] rr_addr [4];
      n_chk   = 0;
      n_fail  = 0;
      resetn  = 1'b0;
      i_valid = 1'b0; i_addr = 32'h0; i_wdata = 32'h0; i_wstrb = 4'h0;
      d_valid = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
      m_ready = 1'b0; m_rdata = 32'h0;
      tick(); tick();
      chk("reset_m", {m_valid, m_addr, m_wstrb}, 64'h0);
      chk("reset_wdata", {32'h0, m_wdata}, 64'h0);
      chk("reset_rdy", {i_ready, d_ready, i_rdata, d_rdata}, 64'h0);
      resetn = 1'b1;
      tick();

      // Single I read, memory answers after two cycles
      i_valid = 1'b1; i_addr = 32'h0000_0100; i_wstrb = 4'h0;
      tick();
      chk("i_rd_req", {m_valid, m_addr, m_wstrb}, {27'h0, 1'b1, 32'h0000_0100, 4'h0});
      chk("i_rd_rdy_busy", {i_ready, d_ready}, 64'h0);
      tick();
      chk("i_rd_hold", {m_valid, i_ready}, 64'h2);
      m_ready = 1'b1; m_rdata = 32'h0000_0013;
      tick();
      m_ready = 1'b0; i_valid = 1'b0;
      chk("i_rd_done", {i_ready, d_ready, m_valid, i_rdata}, {29'h0, 3'b100, 32'h0000_0013});
      tick();
      chk("i_rd_pulse_end", {i_ready, d_ready}, 64'h0);

      // D write; m_ready already high in IDLE must not complete anything
      d_valid = 1'b1; d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
      m_ready = 1'b1; m_rdata = 32'hCAFE_F00D;
      tick();
      chk("d_wr_req", {m_valid, m_addr, m_wstrb}, {27'h0, 1'b1, 32'h0000_2000, 4'hF});
      chk("d_wr_wdata", {32'h0, m_wdata}, {32'h0, 32'hDEAD_BEEF});
      chk("d_wr_not_early", {i_ready, d_ready}, 64'h0);
      tick();
      m_ready = 1'b0; d_valid = 1'b0;
      chk("d_wr_done", {d_ready, i_ready, m_valid}, 64'h4);
      chk("d_wr_rdata", {d_rdata, i_rdata}, {32'hCAFE_F00D, 32'h0000_0013});
      tick();
      chk("d_wr_pulse_end", {i_ready, d_ready}, 64'h0);

      // Simultaneous held requests after reset: RR alternates, fixed always picks I
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      rr_addr[0] = 32'h10; rr_addr[1] = 32'h20; rr_addr[2] = 32'h10; rr_addr[3] = 32'h20;
      i_valid = 1'b1; i_addr = 32'h10; d_valid = 1'b1; d_addr = 32'h20;
      d_wstrb = 4'h0; i_wstrb = 4'h0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("rr_grant%0d", k), {32'h0, m_addr}, {32'h0, rr_addr[k]});
         chk($sformatf("fix_grant%0d", k), {32'h0, m_addr_f}, 64'h10);
         m_ready = 1'b1; m_rdata = k;
         tick();
         m_ready = 1'b0;
         chk($sformatf("rr_rdy%0d", k), {i_ready, d_ready},
             (rr_addr[k] == 32'h10) ? 64'h2 : 64'h1);
         chk($sformatf("fix_rdy%0d", k), {i_ready_f, d_ready_f}, 64'h2);
         tick();
      end
      i_valid = 1'b0; d_valid = 1'b0;
      tick();

      // Long memory stall; requester drops valid mid-transaction
      i_valid = 1'b1; i_addr = 32'h0000_0300;
      tick();
      i_valid = 1'b0;
      for (int c = 0; c < 50; c++) begin
         tick();
         chk("stall_hold", {m_valid, m_addr, i_ready, d_ready},
             {29'h0, 1'b1, 32'h0000_0300, 2'b00});
      end
      m_ready = 1'b1; m_rdata = 32'h0000_0055;
      tick();
      m_ready = 1'b0;
      chk("stall_done", {i_ready, d_ready, i_rdata}, {30'h0, 2'b10, 32'h0000_0055});
      tick();
      chk("stall_after", {m_valid, i_ready, d_ready}, 64'h0);

      // Reset while BUSY abandons the transaction
      d_valid = 1'b1; d_addr = 32'h0000_0400;
      tick();
      chk("rst_busy_req", {m_valid, m_addr}, {31'h0, 1'b1, 32'h0000_0400});
      resetn = 1'b0; d_valid = 1'b0;
      tick();
      resetn = 1'b1;
      chk("rst_busy_clr", {m_valid, i_ready, d_ready}, 64'h0);
      tick();
      chk("rst_no_pulse", {m_valid, i_ready, d_ready}, 64'h0);
      i_valid = 1'b1; i_addr = 32'h0000_0500; d_valid = 1'b1; d_addr = 32'h0000_0404;
      tick();
      chk("rst_first_i", {m_valid, m_addr}, {31'h0, 1'b1, 32'h0000_0500});
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0; i_valid = 1'b0; d_valid = 1'b0;
      chk("rst_first_rdy", {i_ready, d_ready}, 64'h2);
      tick();

      // Back-to-back I then D on single-cycle memory: i_rdata must hold
      i_valid = 1'b1; i_addr = 32'h0000_0600;
      m_ready = 1'b1; m_rdata = 32'h1111_1111;
      tick();
      tick();
      chk("b2b_i_done", {i_ready, i_rdata}, {31'h0, 1'b1, 32'h1111_1111});
      i_valid = 1'b0; d_valid = 1'b1; d_addr = 32'h0000_0700; m_rdata = 32'h2222_2222;
      tick();
      chk("b2b_resp_hold", {32'h0, i_rdata}, 64'h1111_1111);
      tick();
      chk("b2b_d_req", {m_addr, i_rdata}, {32'h0000_0700, 32'h1111_1111});
      tick();
      chk("b2b_d_done", {d_ready, i_ready}, 64'h2);
      chk("b2b_rdata", {d_rdata, i_rdata}, {32'h2222_2222, 32'h1111_1111});
      d_valid = 1'b0; m_ready = 1'b0;
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
